// File: rtl/tx_mux.sv
// Transmit symbol multiplexer: frames a byte stream as STP/data/END (EDB on underrun),
// fills idle time with IDL and, when SKP_INSERT_EN is defined, inserts COM+3xSKP ordered sets.
module tx_mux #(
  parameter int SKP_INTERVAL = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] data_out,
  output logic       k_out,
  output logic [3:0] S,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    ENDS = 3'd2,
    SKP1 = 3'd3,
    SKP2 = 3'd4,
    SKP3 = 3'd5
  } state_t;

  // Output register packing: {symbol type, k flag, byte}
  localparam logic [12:0] SYM_COM = {4'd1, 1'b1, 8'hBC};
  localparam logic [12:0] SYM_PAD = {4'd2, 1'b1, 8'hF7};
  localparam logic [12:0] SYM_SKP = {4'd3, 1'b1, 8'h1C};
  localparam logic [12:0] SYM_STP = {4'd4, 1'b1, 8'hFB};
  localparam logic [12:0] SYM_END = {4'd6, 1'b1, 8'hFD};
  localparam logic [12:0] SYM_EDB = {4'd7, 1'b1, 8'hFE};
  localparam logic [12:0] SYM_IDL = {4'd9, 1'b1, 8'h7C};

  state_t      state;
  logic [12:0] out_reg;
  logic        skp_pending;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only while enabled in DATA, and in_valid must be held until then.
  assign in_ready  = enb && (state == DATA);
  assign {S, k_out, data_out} = out_reg;
  assign state_dbg = state;

`ifdef SKP_INSERT_EN
  localparam int CW = $clog2(SKP_INTERVAL);
  localparam logic [CW-1:0] CNT_MAX = CW'(SKP_INTERVAL - 1);

  logic [CW-1:0] skp_cnt;

  assign skp_pending = (skp_cnt == CNT_MAX);

  // Saturates while a packet holds off the ordered set; restarts when COM goes out.
  always_ff @(posedge clk) begin
    if (reset) begin
      skp_cnt <= '0;
    end else if (enb) begin
      if (state == IDLE && skp_pending) begin
        skp_cnt <= '0;
      end else if (!skp_pending) begin
        skp_cnt <= skp_cnt + 1'b1;
      end
    end
  end
`else
  logic skp_unused;
  assign skp_unused  = ^SKP_INTERVAL;
  assign skp_pending = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      out_reg <= SYM_IDL;
    end else if (!enb) begin
      out_reg <= SYM_PAD;
    end else begin
      unique case (state)
        IDLE: begin
          if (skp_pending) begin
            out_reg <= SYM_COM;
            state   <= SKP1;
          end else if (in_valid) begin
            out_reg <= SYM_STP;
            state   <= DATA;
          end else begin
            out_reg <= SYM_IDL;
          end
        end
        DATA: begin
          if (in_valid) begin
            out_reg <= {4'd0, 1'b0, in_data};
            if (in_last) state <= ENDS;
          end else begin
            out_reg <= SYM_EDB;
            state   <= IDLE;
          end
        end
        ENDS: begin
          out_reg <= SYM_END;
          state   <= IDLE;
        end
        SKP1: begin
          out_reg <= SYM_SKP;
          state   <= SKP2;
        end
        SKP2: begin
          out_reg <= SYM_SKP;
          state   <= SKP3;
        end
        SKP3: begin
          out_reg <= SYM_SKP;
          state   <= IDLE;
        end
        default: begin
          out_reg <= SYM_IDL;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_mux.sv
// Bench for tx_mux: directed framing scenarios plus randomized traffic against a
// queue-based symbol-stream model. Honours SKP_INSERT_EN the same way the design does.
module tb_tx_mux;

  localparam int SKP_I = 8;

  localparam logic [12:0] COM_S = {4'd1, 1'b1, 8'hBC};
  localparam logic [12:0] PAD_S = {4'd2, 1'b1, 8'hF7};
  localparam logic [12:0] SKP_S = {4'd3, 1'b1, 8'h1C};
  localparam logic [12:0] STP_S = {4'd4, 1'b1, 8'hFB};
  localparam logic [12:0] END_S = {4'd6, 1'b1, 8'hFD};
  localparam logic [12:0] EDB_S = {4'd7, 1'b1, 8'hFE};
  localparam logic [12:0] IDL_S = {4'd9, 1'b1, 8'h7C};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enb = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] data_out;
  logic       k_out;
  logic [3:0] S;
  logic [2:0] state_dbg;
  logic [12:0] out_sym;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending fixed symbols, packet-open flag, cycles since last COM
  logic [12:0] sym_q[$];
  bit          m_inpkt;
  int          m_age;
  logic [12:0] e_sym;
  logic        e_ready;
  logic        got_ready;

  tx_mux #(.SKP_INTERVAL(SKP_I)) dut (
    .clk(clk), .reset(reset), .enb(enb),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .data_out(data_out), .k_out(k_out), .S(S),
    .state_dbg(state_dbg)
  );

  assign out_sym = {S, k_out, data_out};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_cycle(input logic r, input logic en, input logic v,
                             input logic [7:0] d, input logic l);
    bit due;
    if (r) begin
      sym_q.delete();
      m_inpkt = 0;
      m_age   = 0;
      e_sym   = IDL_S;
      return;
    end
    if (!en) begin
      e_sym = PAD_S;
      return;
    end
`ifdef SKP_INSERT_EN
    due = (m_age >= SKP_I - 1);
`else
    due = 1'b0;
`endif
    m_age++;
    if (sym_q.size() != 0) begin
      e_sym = sym_q.pop_front();
    end else if (m_inpkt) begin
      if (v) begin
        e_sym = {4'd0, 1'b0, d};
        if (l) begin
          m_inpkt = 0;
          sym_q.push_back(END_S);
        end
      end else begin
        e_sym   = EDB_S;
        m_inpkt = 0;
      end
    end else if (due) begin
      e_sym = COM_S;
      repeat (3) sym_q.push_back(SKP_S);
      m_age = 0;
    end else if (v) begin
      e_sym   = STP_S;
      m_inpkt = 1;
    end else begin
      e_sym = IDL_S;
    end
  endtask

  // One clock: drive inputs, sample in_ready, advance the model, settle past the edge
  task automatic step(input logic r, input logic en, input logic v,
                      input logic [7:0] d, input logic l);
    reset = r; enb = en; in_valid = v; in_data = d; in_last = l;
    #1;
    got_ready = in_ready;
    e_ready   = en && m_inpkt && (sym_q.size() == 0);
    model_cycle(r, en, v, d, l);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0, 8'h00, 0);
    step(1, 1, 0, 8'h00, 0);
    n_checks++;
    if (out_sym !== IDL_S) begin
      n_errors++;
      $display("FAIL reset_out: got %h expected %h", out_sym, IDL_S);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready: got %b expected 0", in_ready);
    end
  endtask

  task automatic test_idle();
    int coms = 0;
    int first_com = -1;
    int exp_coms;
    step(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 24; i++) begin
      step(0, 1, 0, 8'h00, 0);
      n_checks++;
      if (out_sym !== e_sym) begin
        n_errors++;
        $display("FAIL idle_cyc%0d: got %h expected %h", i, out_sym, e_sym);
      end
      if (out_sym === COM_S) begin
        coms++;
        if (first_com < 0) first_com = i;
      end
    end
`ifdef SKP_INSERT_EN
    exp_coms = 3;
    n_checks++;
    if (first_com !== SKP_I - 1) begin
      n_errors++;
      $display("FAIL idle_first_com: got %0d expected %0d", first_com, SKP_I - 1);
    end
`else
    exp_coms = 0;
`endif
    n_checks++;
    if (coms !== exp_coms) begin
      n_errors++;
      $display("FAIL idle_com_count: got %0d expected %0d", coms, exp_coms);
    end
  endtask

  task automatic test_packet();
    logic [12:0] eo[6];
    logic [7:0]  dd[6];
    bit          vv[6];
    bit          ll[6];
    bit          er[6];
    int          ready_cnt = 0;
    eo = '{STP_S, {5'd0, 8'h11}, {5'd0, 8'h22}, {5'd0, 8'h33}, END_S, IDL_S};
    dd = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
    vv = '{1, 1, 1, 1, 0, 0};
    ll = '{0, 0, 0, 1, 0, 0};
    er = '{0, 1, 1, 1, 0, 0};
    step(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, vv[i], dd[i], ll[i]);
      if (got_ready) ready_cnt++;
      n_checks++;
      if (got_ready !== er[i]) begin
        n_errors++;
        $display("FAIL packet_ready%0d: got %b expected %b", i, got_ready, er[i]);
      end
      n_checks++;
      if (out_sym !== eo[i]) begin
        n_errors++;
        $display("FAIL packet_out%0d: got %h expected %h", i, out_sym, eo[i]);
      end
    end
    n_checks++;
    if (ready_cnt !== 3) begin
      n_errors++;
      $display("FAIL packet_ready_count: got %0d expected 3", ready_cnt);
    end
  endtask

  task automatic test_underrun();
    logic [12:0] eo[4];
    bit          vv[4];
    eo = '{STP_S, {5'd0, 8'hAA}, EDB_S, IDL_S};
    vv = '{1, 1, 0, 0};
    step(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, vv[i], 8'hAA, 0);
      n_checks++;
      if (out_sym !== eo[i]) begin
        n_errors++;
        $display("FAIL underrun_out%0d: got %h expected %h", i, out_sym, eo[i]);
      end
    end
  endtask

  task automatic test_ctrl_byte_and_enb();
    logic [12:0] eo[8];
    logic [7:0]  dd[8];
    bit          ee[8];
    bit          vv[8];
    bit          ll[8];
    eo = '{STP_S, {5'd0, 8'h11}, {5'd0, 8'hBC}, PAD_S, PAD_S, {5'd0, 8'h22}, END_S, IDL_S};
    dd = '{8'h11, 8'h11, 8'hBC, 8'h22, 8'h22, 8'h22, 8'h00, 8'h00};
    ee = '{1, 1, 1, 0, 0, 1, 1, 1};
    vv = '{1, 1, 1, 1, 1, 1, 0, 0};
    ll = '{0, 0, 0, 0, 0, 1, 0, 0};
    step(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, ee[i], vv[i], dd[i], ll[i]);
      n_checks++;
      if (out_sym !== eo[i]) begin
        n_errors++;
        $display("FAIL bc_enb_out%0d: got %h expected %h", i, out_sym, eo[i]);
      end
      if (!ee[i]) begin
        n_checks++;
        if (got_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL bc_enb_ready%0d: got %b expected 0", i, got_ready);
        end
      end
    end
  endtask

  task automatic test_skp_collision();
    logic [12:0] exp_q[$];
    logic [7:0]  bytes[5];
    bit          lasts[5];
    int          ptr = 0;
    logic [12:0] want;
    bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1};
    lasts = '{0, 0, 0, 1, 1};
    exp_q = '{STP_S, {5'd0, 8'hA1}, {5'd0, 8'hA2}, {5'd0, 8'hA3}, {5'd0, 8'hA4}, END_S};
`ifdef SKP_INSERT_EN
    exp_q.push_back(COM_S);
    repeat (3) exp_q.push_back(SKP_S);
    exp_q.push_back(STP_S);
    exp_q.push_back({5'd0, 8'hB1});
    exp_q.push_back(END_S);
`else
    exp_q.push_back(STP_S);
    exp_q.push_back({5'd0, 8'hB1});
    exp_q.push_back(END_S);
    repeat (4) exp_q.push_back(IDL_S);
`endif
    step(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 8'h00, 0);
      n_checks++;
      if (out_sym !== IDL_S) begin
        n_errors++;
        $display("FAIL collision_idle%0d: got %h expected %h", i, out_sym, IDL_S);
      end
    end
    for (int i = 0; i < 13; i++) begin
      if (ptr < 5) step(0, 1, 1, bytes[ptr], lasts[ptr]);
      else step(0, 1, 0, 8'h00, 0);
      if (ptr < 5 && got_ready) ptr++;
      want = exp_q.pop_front();
      n_checks++;
      if (out_sym !== want) begin
        n_errors++;
        $display("FAIL collision_out%0d: got %h expected %h", i, out_sym, want);
      end
    end
    n_checks++;
    if (ptr !== 5) begin
      n_errors++;
      $display("FAIL collision_accepted: got %0d expected 5", ptr);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [12:0] want;
    step(1, 1, 0, 8'h00, 0);
    step(0, 1, 1, 8'h11, 0);
    step(0, 1, 1, 8'h11, 0);
    step(1, 1, 1, 8'h22, 0);
    n_checks++;
    if (out_sym !== IDL_S) begin
      n_errors++;
      $display("FAIL midreset_out: got %h expected %h", out_sym, IDL_S);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 8'h00, 0);
`ifdef SKP_INSERT_EN
      want = (i < SKP_I - 1) ? IDL_S : ((i == SKP_I - 1) ? COM_S : SKP_S);
`else
      want = IDL_S;
`endif
      n_checks++;
      if (out_sym !== want) begin
        n_errors++;
        $display("FAIL midreset_after%0d: got %h expected %h", i, out_sym, want);
      end
    end
  endtask

  task automatic test_random();
    logic       r, en, v, l;
    logic [7:0] d;
    step(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 7) != 0);
      v  = ($urandom_range(0, 5) != 0);
      l  = ($urandom_range(0, 4) == 0);
      d  = 8'($urandom_range(0, 255));
      step(r, en, v, d, l);
      n_checks++;
      if (got_ready !== e_ready) begin
        n_errors++;
        $display("FAIL random_ready%0d: got %b expected %b", i, got_ready, e_ready);
      end
      n_checks++;
      if (out_sym !== e_sym) begin
        n_errors++;
        $display("FAIL random_out%0d: got %h expected %h", i, out_sym, e_sym);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_packet();
    test_underrun();
    test_ctrl_byte_and_enb();
    test_skp_collision();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_mux.md
# tx_mux

Transmit-side symbol multiplexer for the PCIe-style lane path. It takes a byte stream over a valid/ready handshake and frames each packet as STP, data, then END. A packet that runs dry mid-stream is closed with EDB. Idle time is filled with IDL, and SKP ordered sets (COM + 3×SKP) are inserted periodically at packet boundaries. Its output carries a symbol-type code in the same 4-bit encoding the receive-side demultiplexer produces, so the two ends can be looped back directly.

## Interface
- SKP_INTERVAL, 32: number of enabled cycles between SKP ordered-set starts (COM to COM); legal range ≥ 5.
- clk  input  1  clock; everything is sampled on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enb  input  1  lane enable; when low, the block freezes.
- in_data  input  8  payload byte.
- in_valid  input  1  in_data/in_last are valid.
- in_last  input  1  marks the final byte of a packet.
- in_ready  output  1  byte is accepted when in_valid && in_ready (combinational).
- data_out  output  8  transmitted symbol (registered).
- k_out  output  1  1 = control symbol, 0 = data byte (registered).
- S  output  4  symbol type (registered):
  - 0 data, 1 COM, 2 PAD, 3 SKP, 4 STP, 5 SDP, 6 END, 7 EDB, 8 FTS, 9 IDL.

## Operation
- Symbol values: COM BC, PAD F7, SKP 1C, STP FB, END FD, EDB FE, IDL 7C. SDP and FTS are never generated.
- A data byte always drives k_out=0 and S=0, even when its value equals a control code (e.g. 0xBC).
- in_ready = enb && (state==DATA). No other state accepts data.
- skp_cnt (clog2(SKP_INTERVAL) bits):
  - increments on every enb cycle and saturates at SKP_INTERVAL-1;
  - skp_pending = (skp_cnt == SKP_INTERVAL-1);
  - clears to 0 on the cycle COM is loaded.
- FSM actions per enb cycle. Each action loads the output register and sets the next state.
  - IDLE:
    - if skp_pending: load COM, go to SKP1;
    - else if in_valid: load STP, go to DATA;
    - else: load IDL, stay.
  - DATA:
    - if in_valid: load in_data; go to ENDS if in_last, else stay;
    - if !in_valid: load EDB, go to IDLE (underrun; packet nullified).
  - ENDS: load END, go to IDLE.
  - SKP1, SKP2, SKP3: load SKP each; advance in order, SKP3 goes to IDLE.
- Simultaneous events:
  - In IDLE, skp_pending beats in_valid. The pending packet waits; in_valid must be held, since in_ready is low.
  - A pending SKP never interrupts a packet. It waits for IDLE, and skp_cnt stays saturated meanwhile.
- enb low:
  - state and skp_cnt hold;
  - in_ready=0;
  - output register loads PAD (F7, k=1, S=2).
  - When enb returns high, operation resumes from the held state.
- reset (any state, including mid-packet):
  - next state IDLE, skp_cnt=0;
  - output register = IDL (7C, k=1, S=9);
  - no END or EDB is emitted for the aborted packet.

## Timing
- Output latency: a byte accepted in cycle n appears on data_out in cycle n+1.
- Packet of N bytes (in_valid held from cycle 0, no SKP pending):
  - STP appears at cycle 1;
  - the bytes appear at cycles 2..N+1;
  - END appears at N+2;
  - IDLE is reached in cycle N+2 (IDL at N+3 if no new packet).
- Back-to-back packets leave no gap beyond END followed by STP; no IDL is emitted between them.
- Ordered set timing:
  - an SKP ordered set occupies 4 consecutive output cycles;
  - with continuous idle and enb high, COM appears every SKP_INTERVAL cycles.
- Reset values of outputs:
  - data_out=7C, k_out=1, S=9;
  - in_ready=0, because the state after reset is IDLE.

## Configuration
- SKP_INSERT_EN:
  - Defined: skp_cnt and ordered-set insertion behave as specified above.
  - Undefined: skp_cnt is removed, skp_pending is tied to 0, and states SKP1–SKP3 are unreachable. The output never carries COM or SKP.

## Test plan
- Idle after reset, enb=1, in_valid=0: every cycle shows 7C/k=1/S=9; with SKP_INSERT_EN and SKP_INTERVAL=8, the sequence BC(S=1), 1C,1C,1C(S=3) starts every 8 cycles.
- Packet 11,22,33 with in_last on 33: output is FB(S=4), 11, 22, 33 (k=0, S=0), then FD(S=6), then 7C; in_ready is high for exactly 3 cycles.
- Underrun: byte AA accepted, then in_valid drops: output is FB, AA, FE(S=7), 7C; no FD is emitted.
- Byte BC inside a packet: output is BC with k=0 and S=0. Dropping enb for 2 cycles mid-packet: output is F7/S=2 twice, then the next byte; the packet completes normally.
- SKP collision: skp_pending high while a packet is in flight: the packet finishes with END, then BC, 1C×3; a queued packet's STP follows after the SKP ordered set.
- Reset asserted on the second byte of a packet: the next output is 7C; no END or EDB appears; skp_cnt restarts, so the first COM comes SKP_INTERVAL cycles later.
